// File: rtl/riscv_defs_pkg.sv
// Shared definitions for the multicycle RISC-V control path: opcode
// constants, the controller state encoding and the datapath select
// encodings used by multicycle_controller and alu_control_unit.
package riscv_defs_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALUWB,
    S_BEQ,
    S_JAL,
    S_TRAP
  } mc_state_e;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_RS1   = 2'b10
  } src_a_e;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } src_b_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    RES_ALUOUT    = 2'b00,
    RES_DATA      = 2'b01,
    RES_ALURESULT = 2'b10
  } result_src_e;

  // States that hold a memory request open until mem_ready.
  function automatic logic is_mem_state(input mc_state_e s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/mc_mem_wait_timer.sv
// Memory wait timer: counts consecutive cycles with an open request and no
// mem_ready, saturating at all-ones, and flags a timeout on the cycle the
// count sits at MEM_WAIT_MAX while the memory is still not ready.
// Ports:
//   clk         clock
//   reset       synchronous active-high reset
//   clear_i     restart the count (controller entering a memory state)
//   mem_req_i   request is open this cycle
//   mem_ready_i memory completes the access this cycle
//   timeout_o   limit reached with no ready; MEM_WAIT_MAX=0 disables it
module mc_mem_wait_timer #(
  parameter int unsigned MEM_WAIT_MAX = 255,
  parameter int unsigned WAIT_W       = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic mem_req_i,
  input  logic mem_ready_i,
  output logic timeout_o
);

  localparam logic [WAIT_W-1:0] LIMIT      = WAIT_W'(MEM_WAIT_MAX);
  localparam logic [WAIT_W-1:0] SAT        = '1;
  localparam bit                TIMEOUT_EN = (MEM_WAIT_MAX != 0);

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || mem_ready_i) begin
      cnt_d = '0;
    end else if (mem_req_i && (cnt_q != SAT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state is updated with <= only, so every flop samples
  // the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // A ready on the limit cycle wins, hence the !mem_ready_i term.
  assign timeout_o = TIMEOUT_EN && mem_req_i && !mem_ready_i && (cnt_q == LIMIT);

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the shared-ALU, unified-memory multicycle CPU datapath.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   opcode, zero, mem_ready    instruction opcode, ALU zero flag, memory done
//   mem_req, mem_write         memory handshake request and direction
//   adr_src                    memory address select (0=PC, 1=result)
//   ir_write, pc_write         IR/old_pc load, PC load
//   reg_write                  register-file write enable
//   alu_src_a, alu_src_b       ALU operand selects
//   alu_op                     ALU operation class for alu_control_unit
//   result_src                 result bus select
//   retire                     one-cycle pulse per completed instruction
//   halted, bus_error          sticky trap status and trap cause
module multicycle_controller
  import riscv_defs_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 255,
  parameter int unsigned WAIT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic       retire,
  output logic       halted,
  output logic       bus_error
);

  mc_state_e state_q, state_d;
  logic      halted_q, bus_error_q;
  logic      req_open;
  logic      timer_clear;
  logic      timeout;

  // Request as seen by the timer; the output copy is additionally gated by reset.
  assign req_open    = is_mem_state(state_q);
  assign timer_clear = (state_d != state_q) && is_mem_state(state_d);

  mc_mem_wait_timer #(
    .MEM_WAIT_MAX (MEM_WAIT_MAX),
    .WAIT_W       (WAIT_W)
  ) u_wait_timer (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (timer_clear),
    .mem_req_i   (req_open),
    .mem_ready_i (mem_ready),
    .timeout_o   (timeout)
  );

  // State register and sticky trap status.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FETCH;
      halted_q    <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == S_TRAP) halted_q    <= 1'b1;
      if (timeout)           bus_error_q <= 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH: begin
        if (mem_ready)    state_d = S_DECODE;
        else if (timeout) state_d = S_TRAP;
      end
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXEC_R;
          OP_ITYPE:          state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: begin
        if (mem_ready)    state_d = S_MEMWB;
        else if (timeout) state_d = S_TRAP;
      end
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: begin
        if (mem_ready)    state_d = S_FETCH;
        else if (timeout) state_d = S_TRAP;
      end
      S_EXEC_R, S_EXEC_I, S_JAL: state_d = S_ALUWB;
      S_ALUWB, S_BEQ:            state_d = S_FETCH;
      S_TRAP:                    state_d = S_TRAP;
      default:                   state_d = S_TRAP;
    endcase
  end

  // Output logic; reset forces every strobe low in the same cycle.
  always_comb begin
    // NOTE: every output is defaulted first so no path through the case
    // leaves a value unassigned and infers a latch.
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    retire     = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALUOP_ADD;
    result_src = RES_ALUOUT;
    if (!reset) begin
      unique case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            // PC+4 goes straight onto the result bus into PC.
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALURESULT;
          end
        end
        S_DECODE: begin
          // Branch target old_pc+imm is parked in alu_out.
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_IMM;
        end
        S_MEMADR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
        end
        S_MEMREAD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
        end
        S_MEMWB: begin
          result_src = RES_DATA;
          reg_write  = 1'b1;
          retire     = 1'b1;
        end
        S_MEMWRITE: begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          adr_src   = 1'b1;
          retire    = mem_ready;
        end
        S_EXEC_R: begin
          alu_src_a = SRCA_RS1;
          alu_op    = ALUOP_FUNCT;
        end
        S_EXEC_I: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          alu_op    = ALUOP_FUNCT;
        end
        S_ALUWB: begin
          reg_write = 1'b1;
          retire    = 1'b1;
        end
        S_BEQ: begin
          alu_src_a = SRCA_RS1;
          alu_op    = ALUOP_SUB;
          pc_write  = zero;
          retire    = 1'b1;
        end
        S_JAL: begin
          // PC takes the target from alu_out while the ALU forms old_pc+4.
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_FOUR;
          pc_write  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign halted    = halted_q;
  assign bus_error = bus_error_q;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = 7'h00;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  // Default-parameter instance.
  logic       a_mem_req, a_mem_write, a_adr_src, a_ir_write, a_pc_write, a_reg_write;
  logic [1:0] a_alu_src_a, a_alu_src_b, a_alu_op, a_result_src;
  logic       a_retire, a_halted, a_bus_error;
  // Short-timeout instance, same inputs.
  logic       b_mem_req, b_mem_write, b_adr_src, b_ir_write, b_pc_write, b_reg_write;
  logic [1:0] b_alu_src_a, b_alu_src_b, b_alu_op, b_result_src;
  logic       b_retire, b_halted, b_bus_error;

  int total = 0;
  int bad   = 0;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

  typedef struct {
    int lat;
    int n_rw;
    int n_pcw;
    int n_irw;
    int n_mw;
    int n_req;
  } obs_t;

  // Per-cycle record of the last instruction (index = cycle number, 1-based).
  logic       r_req [41];
  logic       r_wr  [41];
  logic       r_rw  [41];
  logic       r_pcw [41];
  logic       r_adr [41];
  logic [1:0] r_sa  [41];
  logic [1:0] r_res [41];

  multicycle_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(a_mem_req), .mem_write(a_mem_write), .adr_src(a_adr_src),
    .ir_write(a_ir_write), .pc_write(a_pc_write), .reg_write(a_reg_write),
    .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b), .alu_op(a_alu_op),
    .result_src(a_result_src), .retire(a_retire), .halted(a_halted),
    .bus_error(a_bus_error)
  );

  multicycle_controller #(.MEM_WAIT_MAX(4), .WAIT_W(8)) dut_to (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(b_mem_req), .mem_write(b_mem_write), .adr_src(b_adr_src),
    .ir_write(b_ir_write), .pc_write(b_pc_write), .reg_write(b_reg_write),
    .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b), .alu_op(b_alu_op),
    .result_src(b_result_src), .retire(b_retire), .halted(b_halted),
    .bus_error(b_bus_error)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // Reference model: instruction-level cost and strobe counts from the
  // latency table and the per-class behaviour.
  function automatic obs_t expect_of(input logic [6:0] op, input logic z,
                                     input int wf, input int wd);
    obs_t e;
    bit   is_mem = (op == LW) || (op == SW);
    int   base;
    case (op)
      LW:      base = 5;
      BQ:      base = 3;
      default: base = 4;
    endcase
    e.lat   = base + wf + (is_mem ? wd : 0);
    e.n_rw  = (op == SW || op == BQ) ? 0 : 1;
    e.n_pcw = 1 + ((op == JL) ? 1 : 0) + ((op == BQ && z) ? 1 : 0);
    e.n_irw = 1;
    e.n_mw  = (op == SW) ? wd + 1 : 0;
    e.n_req = wf + 1 + (is_mem ? wd + 1 : 0);
    return e;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Runs one instruction from FETCH, acting as a memory that answers the
  // fetch after wf wait cycles and the data access after wd wait cycles.
  task automatic run_instr(input logic [6:0] op, input logic z, input int wf,
                           input int wd, output obs_t o);
    int acc = 0;
    int w   = 0;
    o = '{0, 0, 0, 0, 0, 0};
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      opcode = op;
      zero   = z;
      if (a_mem_req) begin
        if (w == ((acc == 0) ? wf : wd)) begin
          mem_ready = 1'b1; acc++; w = 0;
        end else begin
          mem_ready = 1'b0; w++;
        end
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      #1;
      r_req[c] = a_mem_req;  r_wr[c] = a_mem_write; r_rw[c] = a_reg_write;
      r_pcw[c] = a_pc_write; r_adr[c] = a_adr_src;  r_sa[c] = a_alu_src_a;
      r_res[c] = a_result_src;
      o.n_rw  += int'(a_reg_write);
      o.n_pcw += int'(a_pc_write);
      o.n_irw += int'(a_ir_write);
      o.n_mw  += int'(a_mem_write);
      o.n_req += int'(a_mem_req);
      if (a_retire) begin
        o.lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b1;
    #1;
    total++;
    if ({a_mem_req, a_mem_write, a_ir_write, a_pc_write, a_reg_write, a_retire} !== 6'b0) begin
      bad++; $display("FAIL reset_strobes: got %b want 000000",
        {a_mem_req, a_mem_write, a_ir_write, a_pc_write, a_reg_write, a_retire});
    end
    total++;
    if ({a_alu_src_a, a_alu_src_b, a_alu_op, a_result_src} !== 8'h00) begin
      bad++; $display("FAIL reset_selects: got %h want 00",
        {a_alu_src_a, a_alu_src_b, a_alu_op, a_result_src});
    end
    do_reset();
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    total++;
    if ({a_halted, a_bus_error, a_mem_req, a_adr_src} !== 4'b0010) begin
      bad++; $display("FAIL reset_fetch: got %b want 0010",
        {a_halted, a_bus_error, a_mem_req, a_adr_src});
    end
  endtask

  task automatic test_lw();
    obs_t o;
    do_reset();
    run_instr(LW, 1'b0, 0, 0, o);
    total++;
    if (o.lat !== 5) begin bad++; $display("FAIL lw_latency: got %0d want 5", o.lat); end
    total++;
    if (o.n_rw !== 1 || r_rw[5] !== 1'b1) begin
      bad++; $display("FAIL lw_reg_write: got count=%0d last=%b want count=1 last=1", o.n_rw, r_rw[5]);
    end
    total++;
    if (r_sa[3] !== 2'b10 || r_adr[4] !== 1'b1 || r_req[4] !== 1'b1 || r_res[5] !== 2'b01) begin
      bad++; $display("FAIL lw_sequence: got srcA3=%b adr4=%b req4=%b res5=%b want 10 1 1 01",
        r_sa[3], r_adr[4], r_req[4], r_res[5]);
    end
  endtask

  task automatic test_sw_wait();
    obs_t o;
    do_reset();
    run_instr(SW, 1'b0, 0, 3, o);
    total++;
    if (o.n_mw !== 4 || r_wr[7] !== 1'b1) begin
      bad++; $display("FAIL sw_write_hold: got cycles=%0d last=%b want 4 1", o.n_mw, r_wr[7]);
    end
    total++;
    if (o.lat !== 7) begin bad++; $display("FAIL sw_latency: got %0d want 7", o.lat); end
    total++;
    if (o.n_rw !== 0) begin bad++; $display("FAIL sw_reg_write: got %0d want 0", o.n_rw); end
  endtask

  task automatic test_beq();
    obs_t o;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      logic z = (k == 0);
      run_instr(BQ, z, 0, 0, o);
      total++;
      if (o.lat !== 3 || r_pcw[3] !== z) begin
        bad++; $display("FAIL beq_zero%0d: got lat=%0d pcw=%b want 3 %b", z, o.lat, r_pcw[3], z);
      end
    end
  endtask

  task automatic test_random();
    obs_t o, e;
    logic [6:0] ops [6] = '{LW, SW, RT, IT, BQ, JL};
    do_reset();
    for (int n = 0; n < 40; n++) begin
      logic [6:0] op = ops[$urandom_range(0, 5)];
      logic       z  = 1'($urandom_range(0, 1));
      int         wf = $urandom_range(0, 3);
      int         wd = $urandom_range(0, 3);
      e = expect_of(op, z, wf, wd);
      run_instr(op, z, wf, wd, o);
      total++;
      if (o.lat !== e.lat || o.n_rw !== e.n_rw || o.n_pcw !== e.n_pcw) begin
        bad++; $display("FAIL rand%0d_op%b: got lat=%0d rw=%0d pcw=%0d want %0d %0d %0d",
          n, op, o.lat, o.n_rw, o.n_pcw, e.lat, e.n_rw, e.n_pcw);
      end
      total++;
      if (o.n_irw !== e.n_irw || o.n_mw !== e.n_mw || o.n_req !== e.n_req) begin
        bad++; $display("FAIL rand%0d_mem: got irw=%0d mw=%0d req=%0d want %0d %0d %0d",
          n, o.n_irw, o.n_mw, o.n_req, e.n_irw, e.n_mw, e.n_req);
      end
    end
  endtask

  task automatic test_illegal();
    do_reset();
    @(negedge clk); opcode = 7'h7F; mem_ready = 1'b1;   // FETCH completes
    @(negedge clk); mem_ready = 1'b0;                   // DECODE
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      total++;
      if ({a_mem_req, a_mem_write, a_ir_write, a_pc_write, a_reg_write, a_retire,
           a_halted, a_bus_error} !== 8'b0000_0010) begin
        bad++; $display("FAIL illegal_trap%0d: got %b want 00000010", k,
          {a_mem_req, a_mem_write, a_ir_write, a_pc_write, a_reg_write, a_retire,
           a_halted, a_bus_error});
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    opcode = RT;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      if (k == 5) begin
        total++;
        if (b_halted !== 1'b0 || b_mem_req !== 1'b1) begin
          bad++; $display("FAIL timeout_limit_cycle: got halted=%b req=%b want 0 1", b_halted, b_mem_req);
        end
      end
    end
    @(negedge clk); #1;
    total++;
    if ({b_halted, b_bus_error, b_mem_req} !== 3'b110) begin
      bad++; $display("FAIL timeout_trap: got %b want 110", {b_halted, b_bus_error, b_mem_req});
    end
    total++;
    if ({a_halted, a_mem_req} !== 2'b01) begin
      bad++; $display("FAIL timeout_default_waits: got %b want 01", {a_halted, a_mem_req});
    end
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      mem_ready = (k == 5);
      #1;
    end
    total++;
    if (b_ir_write !== 1'b1) begin
      bad++; $display("FAIL timeout_ready_wins: got ir_write=%b want 1", b_ir_write);
    end
    @(negedge clk); mem_ready = 1'b0; #1;
    total++;
    if ({b_halted, b_bus_error, b_mem_req, b_alu_src_a} !== 5'b00001) begin
      bad++; $display("FAIL timeout_decode: got %b want 00001",
        {b_halted, b_bus_error, b_mem_req, b_alu_src_a});
    end
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    @(negedge clk); opcode = SW; mem_ready = 1'b1;   // FETCH
    @(negedge clk); mem_ready = 1'b0;                // DECODE
    @(negedge clk);                                  // MEMADR
    @(negedge clk); #1;                              // MEMWRITE, waiting
    total++;
    if ({a_mem_req, a_mem_write} !== 2'b11) begin
      bad++; $display("FAIL midwrite_active: got %b want 11", {a_mem_req, a_mem_write});
    end
    @(negedge clk); reset = 1'b1; #1;
    total++;
    if ({a_mem_req, a_mem_write} !== 2'b00) begin
      bad++; $display("FAIL midwrite_reset_drop: got %b want 00", {a_mem_req, a_mem_write});
    end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk); #1;
    total++;
    if ({a_mem_req, a_mem_write, a_halted, a_adr_src} !== 4'b1000) begin
      bad++; $display("FAIL midwrite_refetch: got %b want 1000",
        {a_mem_req, a_mem_write, a_halted, a_adr_src});
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_beq();
    test_random();
    test_illegal();
    test_timeout();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
